// File: rtl/kbd_cmd_decoder_if.sv
// Keyboard-to-command bundle: strobed ASCII key codes in, FIFO head with valid/ready out.
// slave = decoder side, master = keyboard front end / consumer side.
interface kbd_cmd_decoder_if;
    logic [7:0] kbd_data;
    logic       kbd_strobe;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;

    modport slave (
        input  kbd_data,
        input  kbd_strobe,
        input  cmd_ready,
        output cmd_valid,
        output cmd_code
    );

    modport master (
        output kbd_data,
        output kbd_strobe,
        output cmd_ready,
        input  cmd_valid,
        input  cmd_code
    );
endinterface

// File: rtl/kbd_cmd_decoder.sv
// Transport command decoder: ASCII keys D/E/F/B/R -> player state, restart pulse and a command FIFO.
// Optional macro KBD_CMD_STATS_EN adds a saturating unknown_cnt output for keys that decode to nothing.
module kbd_cmd_decoder #(
    parameter int FIFO_DEPTH       = 4,
    parameter int HOLDOFF_CYCLES   = 0,
    parameter int CASE_INSENSITIVE = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    kbd_cmd_decoder_if.slave   cmd_if,
    output logic               play,
    output logic               dir,
    output logic               restart,
    output logic               overflow
`ifdef KBD_CMD_STATS_EN
    ,
    output logic [15:0]        unknown_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int HO_W  = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_PAUSE   = 3'd1,
        CMD_PLAY    = 3'd2,
        CMD_FWD     = 3'd3,
        CMD_BWD     = 3'd4,
        CMD_RESTART = 3'd5
    } cmd_e;

    function automatic cmd_e decode_key(input logic [7:0] key);
        cmd_e c;
        logic lower_ok;
        lower_ok = (CASE_INSENSITIVE != 0);
        c = CMD_NONE;
        case (key)
            8'h44:   c = CMD_PAUSE;
            8'h45:   c = CMD_PLAY;
            8'h46:   c = CMD_FWD;
            8'h42:   c = CMD_BWD;
            8'h52:   c = CMD_RESTART;
            8'h64:   c = lower_ok ? CMD_PAUSE   : CMD_NONE;
            8'h65:   c = lower_ok ? CMD_PLAY    : CMD_NONE;
            8'h66:   c = lower_ok ? CMD_FWD     : CMD_NONE;
            8'h62:   c = lower_ok ? CMD_BWD     : CMD_NONE;
            8'h72:   c = lower_ok ? CMD_RESTART : CMD_NONE;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

    function automatic logic [HO_W-1:0] sat_dec(input logic [HO_W-1:0] v);
        return (v == '0) ? v : v - HO_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage 1: capture the strobed key
    logic       vld_p1_q;
    logic [7:0] key_p1_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= cmd_if.kbd_strobe;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_if.kbd_strobe) begin
            key_p1_q <= cmd_if.kbd_data;
        end
    end

    // Stage 2: decode, holdoff filter, player state update and FIFO push
    cmd_e            code_p1;
    logic            suppress_p1;
    logic            accept_p1;

    logic            play_q, play_d;
    logic            dir_q, dir_d;
    logic            restart_q, restart_d;
    logic            overflow_q, overflow_d;
    logic [HO_W-1:0] hold_q, hold_d;
    cmd_e            last_q, last_d;

    logic [2:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic            fifo_full;
    logic            fifo_nonempty;
    logic            pop;
    logic            push_ok;

    assign code_p1       = decode_key(key_p1_q);
    assign suppress_p1   = (hold_q != '0) && (code_p1 == last_q);
    assign accept_p1     = vld_p1_q && (code_p1 != CMD_NONE) && !suppress_p1;

    assign fifo_nonempty = (count_q != '0);
    assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop           = fifo_nonempty && cmd_if.cmd_ready;
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign push_ok       = accept_p1 && (!fifo_full || pop);

    always_comb begin
        play_d     = play_q;
        dir_d      = dir_q;
        restart_d  = 1'b0;
        overflow_d = overflow_q;
        hold_d     = sat_dec(hold_q);
        last_d     = last_q;
        if (accept_p1) begin
            hold_d = HO_W'(HOLDOFF_CYCLES);
            last_d = code_p1;
            case (code_p1)
                CMD_PAUSE:   play_d    = 1'b0;
                CMD_PLAY:    play_d    = 1'b1;
                CMD_FWD:     dir_d     = 1'b0;
                CMD_BWD:     dir_d     = 1'b1;
                CMD_RESTART: restart_d = 1'b1;
                default:     ;
            endcase
            if (fifo_full && !pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_comb begin
        wr_d    = push_ok ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = pop ? rd_q + PTR_W'(1) : rd_q;
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            play_q     <= 1'b0;
            dir_q      <= 1'b0;
            restart_q  <= 1'b0;
            overflow_q <= 1'b0;
            hold_q     <= '0;
            last_q     <= CMD_NONE;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
        end else begin
            play_q     <= play_d;
            dir_q      <= dir_d;
            restart_q  <= restart_d;
            overflow_q <= overflow_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= code_p1;
        end
    end

`ifdef KBD_CMD_STATS_EN
    logic        unknown_p1;
    logic [15:0] unk_q, unk_d;

    assign unknown_p1 = vld_p1_q && (code_p1 == CMD_NONE);
    assign unk_d      = unknown_p1 ? sat_inc16(unk_q) : unk_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            unk_q <= 16'd0;
        end else begin
            unk_q <= unk_d;
        end
    end

    assign unknown_cnt = unk_q;
`endif

    assign play             = play_q;
    assign dir              = dir_q;
    assign restart          = restart_q;
    assign overflow         = overflow_q;
    assign cmd_if.cmd_valid = fifo_nonempty;
    assign cmd_if.cmd_code  = fifo_nonempty ? mem_q[rd_q] : 3'd0;

endmodule
